// File: rtl/ascon_arb_pkg.sv
// Shared types and sizing for the two-requester Ascon session arbiter.
package ascon_arb_pkg;

  localparam int DATA_W    = 64;
  localparam int NB_BLOCKS = 4;
  localparam int NB_CIPHER = 3;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_FEED  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } arb_state_t;

endpackage

// File: rtl/arb_pick.sv
// Two-way winner select; ptr names the requester that wins a tie.
module arb_pick
  import ascon_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       ptr,
  output logic [1:0] gnt
);

  // Requester 0 wins unless the pointer favours requester 1 and both ask
  always_comb begin
    gnt = 2'b00;
    if (req[0] && (!ptr || !req[1])) begin
      gnt = 2'b01;
    end else if (req[1]) begin
      gnt = 2'b10;
    end else begin
      gnt = 2'b00;
    end
  end

endmodule

// File: rtl/ascon_arbiter.sv
// Arbitrates two requesters onto one Ascon core: grant, 4-block feed, drain, done.
// Optional build macro ASCON_ARB_FAIR_EN selects round-robin instead of fixed priority.
module ascon_arbiter
  import ascon_arb_pkg::*;
(
  input  logic              clock_i,
  input  logic              reset_i,
  input  logic [1:0]        req_i,
  output logic [1:0]        gnt_o,
  input  logic [1:0]        blk_valid_i,
  input  logic [DATA_W-1:0] blk0_i,
  input  logic [DATA_W-1:0] blk1_i,
  output logic [1:0]        blk_ready_o,
  output logic              core_start_o,
  output logic              core_data_valid_o,
  output logic [DATA_W-1:0] core_data_o,
  input  logic              core_xor_i,
  input  logic              core_cipher_valid_i,
  input  logic [DATA_W-1:0] core_cipher_i,
  input  logic              core_end_i,
  output logic [1:0]        cipher_valid_o,
  output logic [DATA_W-1:0] cipher_o,
  output logic [1:0]        done_o,
  output logic              busy_o
);

  arb_state_t        state_r, state_nx_s;
  logic [1:0]        gnt_r, gnt_nx_s, pick_s;
  logic              ptr_s;
  logic [DATA_W-1:0] hold_r, hold_nx_s;
  logic              full_r, full_nx_s;
  logic [2:0]        cnt_r, cnt_nx_s;
  logic              err_r, err_nx_s;
  logic              start_r, busy_r;
  logic [1:0]        done_r;
  logic              accept_s, xor_ok_s;

  arb_pick u_pick (
    .req (req_i),
    .ptr (ptr_s),
    .gnt (pick_s)
  );

`ifdef ASCON_ARB_FAIR_EN
  logic ptr_r;

  // Round-robin pointer: after a session, favour the requester not just served
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      ptr_r <= 1'b0;
    end else if (state_r == ST_DONE) begin
      ptr_r <= gnt_r[0];
    end else begin
      ptr_r <= ptr_r;
    end
  end

  assign ptr_s = ptr_r;
`else
  assign ptr_s = 1'b0;
`endif

  // Ready only towards the granted requester while the holding register is free
  always_comb begin
    blk_ready_o = 2'b00;
    if ((state_r == ST_FEED) && !full_r && (cnt_r < 3'(NB_BLOCKS))) begin
      blk_ready_o = gnt_r;
    end else begin
      blk_ready_o = 2'b00;
    end
  end

  assign accept_s = |(blk_valid_i & blk_ready_o);
  assign xor_ok_s = core_xor_i & full_r;

  // Session sequencing and grant capture
  always_comb begin
    state_nx_s = state_r;
    gnt_nx_s   = gnt_r;
    case (state_r)
      ST_IDLE: begin
        if (|req_i) begin
          state_nx_s = ST_START;
          gnt_nx_s   = pick_s;
        end else begin
          gnt_nx_s   = 2'b00;
        end
      end
      ST_START: state_nx_s = ST_FEED;
      ST_FEED: begin
        if (xor_ok_s && (cnt_r == 3'(NB_BLOCKS - 1))) begin
          state_nx_s = ST_DRAIN;
        end else begin
          state_nx_s = ST_FEED;
        end
      end
      ST_DRAIN: begin
        if (core_end_i) begin
          state_nx_s = ST_DONE;
        end else begin
          state_nx_s = ST_DRAIN;
        end
      end
      ST_DONE: begin
        state_nx_s = ST_IDLE;
        gnt_nx_s   = 2'b00;
      end
      default: begin
        state_nx_s = ST_IDLE;
        gnt_nx_s   = 2'b00;
      end
    endcase
  end

  // Holding register, block counter and sticky protocol error
  always_comb begin
    hold_nx_s = hold_r;
    full_nx_s = full_r;
    cnt_nx_s  = cnt_r;
    if (accept_s) begin
      hold_nx_s = gnt_r[1] ? blk1_i : blk0_i;
      full_nx_s = 1'b1;
    end else if (xor_ok_s) begin
      full_nx_s = 1'b0;
    end else begin
      full_nx_s = full_r;
    end
    if (state_r == ST_IDLE) begin
      cnt_nx_s = 3'd0;
    end else if (xor_ok_s && (cnt_r < 3'(NB_BLOCKS))) begin
      cnt_nx_s = cnt_r + 3'd1;
    end else begin
      cnt_nx_s = cnt_r;
    end
    err_nx_s = err_r | (core_xor_i & ~full_r) | (core_end_i & (state_r != ST_DRAIN));
  end

  // State and registered outputs
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_r <= ST_IDLE;
      gnt_r   <= 2'b00;
      hold_r  <= '0;
      full_r  <= 1'b0;
      cnt_r   <= 3'd0;
      err_r   <= 1'b0;
      start_r <= 1'b0;
      done_r  <= 2'b00;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_nx_s;
      gnt_r   <= gnt_nx_s;
      hold_r  <= hold_nx_s;
      full_r  <= full_nx_s;
      cnt_r   <= cnt_nx_s;
      err_r   <= err_nx_s;
      start_r <= (state_nx_s == ST_START);
      done_r  <= (state_nx_s == ST_DONE) ? gnt_r : 2'b00;
      busy_r  <= (state_nx_s != ST_IDLE) | err_nx_s;
    end
  end

  assign gnt_o             = gnt_r;
  assign core_start_o      = start_r;
  assign core_data_valid_o = full_r;
  assign core_data_o       = hold_r;
  assign cipher_o          = core_cipher_i;
  assign cipher_valid_o    = {2{core_cipher_valid_i}} & gnt_r;
  assign done_o            = done_r;
  assign busy_o            = busy_r;

endmodule

// File: tb/tb_ascon_arbiter.sv
// Directed bench for ascon_arbiter: cycle table for one session plus hand sequences.
module tb_ascon_arbiter;

  logic        clock_i = 1'b0;
  logic        reset_i = 1'b1;
  logic [1:0]  req_i = 2'b00;
  logic [1:0]  gnt_o;
  logic [1:0]  blk_valid_i = 2'b00;
  logic [63:0] blk0_i = 64'h0;
  logic [63:0] blk1_i = 64'h0;
  logic [1:0]  blk_ready_o;
  logic        core_start_o, core_data_valid_o;
  logic [63:0] core_data_o;
  logic        core_xor_i = 1'b0;
  logic        core_cipher_valid_i = 1'b0;
  logic [63:0] core_cipher_i = 64'h0;
  logic        core_end_i = 1'b0;
  logic [1:0]  cipher_valid_o;
  logic [63:0] cipher_o;
  logic [1:0]  done_o;
  logic        busy_o;

  int checks = 0;
  int errors = 0;

  ascon_arbiter dut (
    .clock_i(clock_i), .reset_i(reset_i), .req_i(req_i), .gnt_o(gnt_o),
    .blk_valid_i(blk_valid_i), .blk0_i(blk0_i), .blk1_i(blk1_i), .blk_ready_o(blk_ready_o),
    .core_start_o(core_start_o), .core_data_valid_o(core_data_valid_o), .core_data_o(core_data_o),
    .core_xor_i(core_xor_i), .core_cipher_valid_i(core_cipher_valid_i), .core_cipher_i(core_cipher_i),
    .core_end_i(core_end_i), .cipher_valid_o(cipher_valid_o), .cipher_o(cipher_o),
    .done_o(done_o), .busy_o(busy_o)
  );

  always #5 clock_i = ~clock_i;

  localparam logic [63:0] B0 = 64'h0011223344556677;
  localparam logic [63:0] B1 = 64'h0011223344556678;
  localparam logic [63:0] B2 = 64'h0011223344556679;
  localparam logic [63:0] B3 = 64'h001122334455667A;
  localparam logic [63:0] C0 = 64'hC0FFEE0000000001;
  localparam logic [63:0] C1 = 64'hC0FFEE0000000002;
  localparam logic [63:0] C2 = 64'hC0FFEE0000000003;

`ifdef ASCON_ARB_FAIR_EN
  localparam logic [1:0] SECOND_GNT = 2'b10;
`else
  localparam logic [1:0] SECOND_GNT = 2'b01;
`endif

  typedef struct {
    logic [1:0]  req;
    logic [1:0]  bv;
    logic [63:0] blk;
    logic        xr;
    logic        cv;
    logic [63:0] cdat;
    logic        cend;
    logic [1:0]  e_gnt;
    logic        e_start;
    logic [1:0]  e_rdy;
    logic        e_dv;
    logic [63:0] e_data;
    logic [1:0]  e_cvo;
    logic [1:0]  e_done;
    logic        e_busy;
  } vec_t;

  vec_t tbl[15];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_gnt"}, gnt_o, 64'd0);
    chk({tag, "_start"}, core_start_o, 64'd0);
    chk({tag, "_rdy"}, blk_ready_o, 64'd0);
    chk({tag, "_dv"}, core_data_valid_o, 64'd0);
    chk({tag, "_data"}, core_data_o, 64'd0);
    chk({tag, "_done"}, done_o, 64'd0);
    chk({tag, "_busy"}, busy_o, 64'd0);
  endtask

  task automatic idle_inputs();
    req_i = 2'b00; blk_valid_i = 2'b00; core_xor_i = 1'b0;
    core_cipher_valid_i = 1'b0; core_end_i = 1'b0;
  endtask

  task automatic do_reset(input string tag);
    @(negedge clock_i);
    idle_inputs();
    reset_i = 1'b1;
    @(negedge clock_i);
    chk_all_zero(tag);
    reset_i = 1'b0;
  endtask

  // Wait (bounded) for ready towards g, then hand over one block
  task automatic give_block(input logic [1:0] g, input logic [63:0] d);
    int n;
    n = 0;
    while (((blk_ready_o & g) == 2'b00) && (n < 8)) begin
      @(negedge clock_i);
      n++;
    end
    chk("rdy_wait", (n < 8), 64'd1);
    blk_valid_i = g; blk0_i = d; blk1_i = d;
    @(negedge clock_i);
    blk_valid_i = 2'b00;
    chk("held_dv", core_data_valid_o, 64'd1);
    chk("held_data", core_data_o, d);
  endtask

  task automatic do_session(input logic [1:0] rq, input logic [1:0] exp_g, input int stall,
                            input logic [63:0] base);
    int low;
    @(negedge clock_i);
    req_i = rq;
    @(negedge clock_i);
    req_i = 2'b00;
    chk("sess_gnt", gnt_o, exp_g);
    chk("sess_start", core_start_o, 64'd1);
    for (int b = 0; b < 4; b++) begin
      if (b == 2) begin
        low = 0;
        for (int s = 0; s < stall; s++) begin
          @(negedge clock_i);
          if (!core_data_valid_o) low++;
        end
        chk("stall_dv_low", low, stall);
      end
      give_block(exp_g, base + 64'(b));
      core_xor_i = 1'b1;
      @(negedge clock_i);
      core_xor_i = 1'b0;
    end
    chk("no_fifth_rdy", blk_ready_o, 64'd0);
    chk("drain_dv", core_data_valid_o, 64'd0);
    core_cipher_valid_i = 1'b1;
    core_cipher_i = ~base;
    #1;
    chk("sess_cvo", cipher_valid_o, exp_g);
    chk("sess_cipher", cipher_o, ~base);
    @(negedge clock_i);
    core_cipher_valid_i = 1'b0;
    core_end_i = 1'b1;
    chk("early_done", done_o, 64'd0);
    @(negedge clock_i);
    core_end_i = 1'b0;
    chk("sess_done", done_o, exp_g);
    chk("sess_done_busy", busy_o, 64'd1);
    @(negedge clock_i);
    chk("post_done", done_o, 64'd0);
    chk("post_gnt", gnt_o, 64'd0);
    chk("post_busy", busy_o, 64'd0);
  endtask

  initial begin
    // req, bv, blk, xr, cv, cdat, cend | gnt, start, rdy, dv, data, cvo, done, busy
    tbl[0]  = '{2'b01, 2'b00, 64'h0, 1'b0, 1'b0, 64'h0, 1'b0, 2'b00, 1'b0, 2'b00, 1'b0, 64'h0, 2'b00, 2'b00, 1'b0};
    tbl[1]  = '{2'b00, 2'b00, 64'h0, 1'b0, 1'b0, 64'h0, 1'b0, 2'b01, 1'b1, 2'b00, 1'b0, 64'h0, 2'b00, 2'b00, 1'b1};
    tbl[2]  = '{2'b00, 2'b01, B0,    1'b0, 1'b0, 64'h0, 1'b0, 2'b01, 1'b0, 2'b01, 1'b0, 64'h0, 2'b00, 2'b00, 1'b1};
    tbl[3]  = '{2'b00, 2'b00, 64'h0, 1'b1, 1'b1, C0,    1'b0, 2'b01, 1'b0, 2'b00, 1'b1, B0,    2'b01, 2'b00, 1'b1};
    tbl[4]  = '{2'b00, 2'b01, B1,    1'b0, 1'b0, 64'h0, 1'b0, 2'b01, 1'b0, 2'b01, 1'b0, 64'h0, 2'b00, 2'b00, 1'b1};
    tbl[5]  = '{2'b00, 2'b00, 64'h0, 1'b1, 1'b0, 64'h0, 1'b0, 2'b01, 1'b0, 2'b00, 1'b1, B1,    2'b00, 2'b00, 1'b1};
    tbl[6]  = '{2'b00, 2'b01, B2,    1'b0, 1'b0, 64'h0, 1'b0, 2'b01, 1'b0, 2'b01, 1'b0, 64'h0, 2'b00, 2'b00, 1'b1};
    tbl[7]  = '{2'b00, 2'b00, 64'h0, 1'b1, 1'b1, C1,    1'b0, 2'b01, 1'b0, 2'b00, 1'b1, B2,    2'b01, 2'b00, 1'b1};
    tbl[8]  = '{2'b00, 2'b01, B3,    1'b0, 1'b0, 64'h0, 1'b0, 2'b01, 1'b0, 2'b01, 1'b0, 64'h0, 2'b00, 2'b00, 1'b1};
    tbl[9]  = '{2'b00, 2'b00, 64'h0, 1'b1, 1'b0, 64'h0, 1'b0, 2'b01, 1'b0, 2'b00, 1'b1, B3,    2'b00, 2'b00, 1'b1};
    tbl[10] = '{2'b00, 2'b00, 64'h0, 1'b0, 1'b1, C2,    1'b0, 2'b01, 1'b0, 2'b00, 1'b0, 64'h0, 2'b01, 2'b00, 1'b1};
    tbl[11] = '{2'b00, 2'b00, 64'h0, 1'b0, 1'b0, 64'h0, 1'b1, 2'b01, 1'b0, 2'b00, 1'b0, 64'h0, 2'b00, 2'b00, 1'b1};
    tbl[12] = '{2'b10, 2'b00, 64'h0, 1'b0, 1'b0, 64'h0, 1'b0, 2'b01, 1'b0, 2'b00, 1'b0, 64'h0, 2'b00, 2'b01, 1'b1};
    tbl[13] = '{2'b00, 2'b00, 64'h0, 1'b0, 1'b0, 64'h0, 1'b0, 2'b00, 1'b0, 2'b00, 1'b0, 64'h0, 2'b00, 2'b00, 1'b0};
    tbl[14] = '{2'b00, 2'b00, 64'h0, 1'b0, 1'b0, 64'h0, 1'b0, 2'b00, 1'b0, 2'b00, 1'b0, 64'h0, 2'b00, 2'b00, 1'b0};

    do_reset("rst0");

    for (int i = 0; i < 15; i++) begin
      @(negedge clock_i);
      req_i = tbl[i].req; blk_valid_i = tbl[i].bv;
      blk0_i = tbl[i].blk; blk1_i = ~tbl[i].blk;
      core_xor_i = tbl[i].xr; core_cipher_valid_i = tbl[i].cv;
      core_cipher_i = tbl[i].cdat; core_end_i = tbl[i].cend;
      #1;
      chk($sformatf("t%0d_gnt", i), gnt_o, tbl[i].e_gnt);
      chk($sformatf("t%0d_start", i), core_start_o, tbl[i].e_start);
      chk($sformatf("t%0d_rdy", i), blk_ready_o, tbl[i].e_rdy);
      chk($sformatf("t%0d_dv", i), core_data_valid_o, tbl[i].e_dv);
      if (tbl[i].e_dv) chk($sformatf("t%0d_data", i), core_data_o, tbl[i].e_data);
      chk($sformatf("t%0d_cvo", i), cipher_valid_o, tbl[i].e_cvo);
      if (tbl[i].cv) chk($sformatf("t%0d_cipher", i), cipher_o, tbl[i].cdat);
      chk($sformatf("t%0d_done", i), done_o, tbl[i].e_done);
      chk($sformatf("t%0d_busy", i), busy_o, tbl[i].e_busy);
    end
    idle_inputs();

    // Tie handling: fixed priority repeats requester 0, round-robin alternates
    do_reset("rst1");
    do_session(2'b11, 2'b01, 0, 64'h1000000000000000);
    do_session(2'b11, SECOND_GNT, 0, 64'h2000000000000000);

    // Block 2 withheld for 20 cycles
    do_session(2'b01, 2'b01, 20, 64'h3000000000000000);

    // Reset while block 2 is held, then a fresh session from requester 1
    @(negedge clock_i);
    req_i = 2'b01;
    @(negedge clock_i);
    req_i = 2'b00;
    for (int b = 0; b < 3; b++) begin
      give_block(2'b01, 64'h4000000000000000 + 64'(b));
      if (b < 2) begin
        core_xor_i = 1'b1;
        @(negedge clock_i);
        core_xor_i = 1'b0;
      end
    end
    reset_i = 1'b1;
    @(negedge clock_i);
    reset_i = 1'b0;
    chk_all_zero("midrst");
    for (int k = 0; k < 3; k++) begin
      @(negedge clock_i);
      chk("midrst_no_done", done_o, 64'd0);
    end
    do_session(2'b10, 2'b10, 0, 64'h5000000000000000);

    // Stray xor strobe with empty register: sticky error
    @(negedge clock_i);
    core_xor_i = 1'b1;
    @(negedge clock_i);
    core_xor_i = 1'b0;
    chk("err_xor_busy", busy_o, 64'd1);
    chk("err_xor_dv", core_data_valid_o, 64'd0);
    repeat (5) @(negedge clock_i);
    chk("err_xor_sticky", busy_o, 64'd1);
    chk("err_xor_gnt", gnt_o, 64'd0);
    do_reset("rst_err1");

    // End strobe outside DRAIN: sticky error
    @(negedge clock_i);
    core_end_i = 1'b1;
    @(negedge clock_i);
    core_end_i = 1'b0;
    chk("err_end_busy", busy_o, 64'd1);
    chk("err_end_done", done_o, 64'd0);
    do_reset("rst_err2");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
